// File: rtl/instr_mem.sv
// instr_mem: byte-addressed, handshaked, registered-read instruction memory.
// After reset the array is cleared to NOP one word per cycle (INIT), then
// fetches and boot-load writes are served (RUN).
// Optional feature macro: IMEM_FAULT_EN -- flags misaligned / out-of-range
// fetches and returns NOP for them. When undefined, low address bits are
// ignored and the word index wraps through truncation to IW bits.
module instr_mem #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 32,
    parameter int unsigned IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] address,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [N-1:0]  instr,
    output logic          fault,
    output logic [1:0]    fault_code,
    input  logic          load_en,
    input  logic [IW-1:0] load_addr,
    input  logic [N-1:0]  load_data,
    output logic          init_done
);

    localparam int unsigned BW  = N / 8;
    localparam int unsigned OFS = $clog2(BW);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [IW-1:0] cnt;
    logic [IW-1:0] cnt_nxt;

    logic [N-1:0]  mem [DEPTH];

    logic          accept_c;
    logic [AW-1:0] widx_c;
    logic [IW-1:0] idx_c;
    logic          idx_ok_c;
    logic          ld_ok_c;
    logic [N-1:0]  rdata_c;
    logic          fault_nxt_c;
    logic [1:0]    code_nxt_c;

    // Handshake: fetch only after the clear, and only when the output slot frees up
    assign init_done = (state == S_RUN);
    assign req_ready = init_done & (~instr_valid | instr_ready);
    assign accept_c  = req_valid & req_ready;

    // Byte address to word index; bits above IW only matter for the range check
    assign widx_c = address >> OFS;
    assign idx_c  = widx_c[IW-1:0];

    // Bounds checks are only needed when DEPTH leaves unused index codes
    generate
        if (DEPTH == (1 << IW)) begin : g_pow2
            assign idx_ok_c = 1'b1;
            assign ld_ok_c  = 1'b1;
        end else begin : g_npow2
            assign idx_ok_c = (idx_c < IW'(DEPTH));
            assign ld_ok_c  = (load_addr < IW'(DEPTH));
        end
    endgenerate

`ifdef IMEM_FAULT_EN
    logic mis_c;
    logic oor_c;

    // Fault classification; a faulting fetch returns NOP instead of reading memory
    assign mis_c       = |(address & AW'(BW - 1));
    assign oor_c       = (widx_c >= AW'(DEPTH));
    assign fault_nxt_c = mis_c | oor_c;
    assign code_nxt_c  = {oor_c, mis_c};
    assign rdata_c     = (fault_nxt_c || !idx_ok_c) ? '0 : mem[idx_c];
`else
    logic unused_addr_c;

    // No fault reporting; truncated index wraps, holes in a non-power-of-2 array read 0
    assign fault_nxt_c   = 1'b0;
    assign code_nxt_c    = 2'b00;
    assign rdata_c       = idx_ok_c ? mem[idx_c] : '0;
    assign unused_addr_c = ^{address, widx_c};
`endif

    // FSM state and clear counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: walk cnt across the array, leave INIT after the last word
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_INIT: begin
                cnt_nxt = cnt + IW'(1);
                if (cnt == IW'(DEPTH - 1)) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                state_nxt = S_RUN;
            end
            default: begin
                state_nxt = S_INIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Array write port: clear during INIT, boot-load in RUN (out-of-range loads dropped)
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[cnt] <= '0;
        end else if (load_en && ld_ok_c) begin
            mem[load_addr] <= load_data;
        end
    end

    // Output register: load on accept, drop valid on drain, hold everything on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            fault       <= 1'b0;
            fault_code  <= 2'b00;
        end else if (accept_c) begin
            instr_valid <= 1'b1;
            instr       <= rdata_c;
            fault       <= fault_nxt_c;
            fault_code  <= code_nxt_c;
        end else if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

endmodule
